// File: rtl/data_memory_unit_if.sv
// Load/store bus between the core datapath and the data memory unit.
// The master drives the access, the slave returns load data and fault/count status.
interface data_memory_unit_if;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        misaligned;
  logic        faultSticky;
  logic [31:0] faultAddr;
  logic [15:0] storeCount;

  modport master (
    output memRead, memWrite, funct3, aluResult, writeData,
    input  readData, misaligned, faultSticky, faultAddr, storeCount
  );

  modport slave (
    input  memRead, memWrite, funct3, aluResult, writeData,
    output readData, misaligned, faultSticky, faultAddr, storeCount
  );
endinterface

// File: rtl/data_memory_unit.sv
// Word-organised data memory with RV32I byte/half/word load-store semantics,
// combinational loads, byte-enabled stores and sticky misalignment capture.
module data_memory_unit #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  data_memory_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic          faultSticky_q, faultSticky_d;
  logic [31:0]   faultAddr_q, faultAddr_d;
  logic [15:0]   storeCount_q, storeCount_d;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [15:0]   rd_half;
  logic [31:0]   rd_ext;
  logic          ld_ok, st_ok, f3_ok, mis_raw, mis, commit;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic          unused_addr;

  assign idx         = bus.aluResult[AW+1:2];
  assign lane        = bus.aluResult[1:0];
  assign unused_addr = ^bus.aluResult[31:AW+2];
  assign rd_word     = mem_q[idx];
  assign rd_shift    = rd_word >> {lane, 3'b000};
  assign rd_half     = lane[1] ? rd_word[31:16] : rd_word[15:0];

  assign ld_ok   = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
  assign st_ok   = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
  // A simultaneous read+write is a store, so the store encoding set decides validity.
  assign f3_ok   = bus.memWrite ? st_ok : ld_ok;
  assign mis_raw = ((bus.funct3[1:0] == 2'b01) && lane[0]) ||
                   ((bus.funct3[1:0] == 2'b10) && (lane != 2'b00));
  assign mis     = (bus.memRead || bus.memWrite) && f3_ok && mis_raw;
  assign commit  = bus.memWrite && st_ok && !mis_raw;

  always_comb begin
    rd_ext = '0;
    case (bus.funct3)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = rd_word;
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = '0;
    endcase
  end

  always_comb begin
    be   = 4'b0000;
    wdat = bus.writeData;
    case (bus.funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << lane;
        wdat = {4{bus.writeData[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.writeData[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    faultSticky_d = faultSticky_q;
    faultAddr_d   = faultAddr_q;
    storeCount_d  = storeCount_q;
    if (mis && !faultSticky_q) begin
      faultSticky_d = 1'b1;
      faultAddr_d   = bus.aluResult;
    end
    if (commit && (storeCount_q != 16'hFFFF)) storeCount_d = storeCount_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      faultSticky_q <= 1'b0;
      faultAddr_q   <= '0;
      storeCount_q  <= '0;
    end else begin
      if (commit) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) mem_q[idx][8*k +: 8] <= wdat[8*k +: 8];
        end
      end
      faultSticky_q <= faultSticky_d;
      faultAddr_q   <= faultAddr_d;
      storeCount_q  <= storeCount_d;
    end
  end

  assign bus.readData    = mis ? 32'd0 : rd_ext;
  assign bus.misaligned  = mis;
  assign bus.faultSticky = faultSticky_q;
  assign bus.faultAddr   = faultAddr_q;
  assign bus.storeCount  = storeCount_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed scoreboard bench for data_memory_unit: expectations are queued as each
// access is driven and compared against the DUT outputs mid-cycle.
module tb_data_memory_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;
  exp_t sb[$];

  data_memory_unit_if bus();

  data_memory_unit #(.DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.funct3    = f3;
    bus.aluResult = addr;
    bus.writeData = wd;
  endtask

  // kind: 0 readData, 1 misaligned, 2 faultSticky, 3 faultAddr, 4 storeCount
  task automatic expect_v(input int kind, input logic [31:0] e, input string tag);
    exp_t x;
    x.kind = kind;
    x.exp  = e;
    x.tag  = tag;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t x;
    logic [31:0] obs;
    #3;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.kind)
        0:       obs = bus.readData;
        1:       obs = {31'd0, bus.misaligned};
        2:       obs = {31'd0, bus.faultSticky};
        3:       obs = bus.faultAddr;
        default: obs = {16'd0, bus.storeCount};
      endcase
      checks++;
      assert (obs === x.exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", x.tag, obs, x.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.funct3 = 3'b010;
    bus.aluResult = '0; bus.writeData = '0;

    step(1, 0, 0, 3'b010, 32'h0, 32'h0);
    step(1, 0, 0, 3'b010, 32'h0, 32'h0);
    step(0, 1, 0, 3'b010, 32'h10, 32'h0);
    expect_v(0, 32'h0, "reset_rd");      expect_v(1, 32'h0, "reset_mis");
    expect_v(2, 32'h0, "reset_sticky");  expect_v(3, 32'h0, "reset_faddr");
    expect_v(4, 32'h0, "reset_cnt");
    check_now();

    step(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    expect_v(1, 32'h0, "sw_mis");
    check_now();
    step(0, 1, 0, 3'b010, 32'h10, 32'h0);
    expect_v(0, 32'hDEADBEEF, "lw_10");  expect_v(4, 32'd1, "cnt_1");
    check_now();

    step(0, 1, 0, 3'b000, 32'h13, 32'h0); expect_v(0, 32'hFFFFFFDE, "lb_13");  check_now();
    step(0, 1, 0, 3'b100, 32'h13, 32'h0); expect_v(0, 32'h000000DE, "lbu_13"); check_now();
    step(0, 1, 0, 3'b001, 32'h12, 32'h0); expect_v(0, 32'hFFFFDEAD, "lh_12");  check_now();
    step(0, 1, 0, 3'b101, 32'h10, 32'h0); expect_v(0, 32'h0000BEEF, "lhu_10"); check_now();
    step(0, 1, 0, 3'b000, 32'h10, 32'h0); expect_v(0, 32'hFFFFFFEF, "lb_10");  check_now();

    step(0, 0, 1, 3'b000, 32'h11, 32'h12345678);
    step(0, 1, 0, 3'b010, 32'h10, 32'h0); expect_v(0, 32'hDEAD78EF, "sb_11"); check_now();
    step(0, 0, 1, 3'b001, 32'h12, 32'hAAAA5555);
    step(0, 1, 0, 3'b010, 32'h10, 32'h0);
    expect_v(0, 32'h555578EF, "sh_12"); expect_v(4, 32'd3, "cnt_3");
    check_now();

    // Invalid funct3 store and load: no write, no count, no fault.
    step(0, 0, 1, 3'b011, 32'h10, 32'h0);
    expect_v(1, 32'h0, "bad_st_mis");
    check_now();
    step(0, 1, 0, 3'b110, 32'h10, 32'h0);
    expect_v(0, 32'h0, "bad_ld_rd"); expect_v(1, 32'h0, "bad_ld_mis");
    expect_v(4, 32'd3, "bad_st_cnt"); expect_v(2, 32'h0, "bad_no_fault");
    check_now();
    step(0, 1, 0, 3'b010, 32'h10, 32'h0); expect_v(0, 32'h555578EF, "bad_st_mem"); check_now();

    step(0, 0, 1, 3'b010, 32'h21, 32'hFFFFFFFF);
    expect_v(1, 32'h1, "sw21_mis"); expect_v(2, 32'h0, "sw21_sticky_pre");
    check_now();
    step(0, 1, 0, 3'b010, 32'h20, 32'h0);
    expect_v(0, 32'h0, "sw21_mem"); expect_v(2, 32'h1, "sticky_set");
    expect_v(3, 32'h21, "faddr_21"); expect_v(4, 32'd3, "mis_cnt");
    expect_v(1, 32'h0, "lw20_mis");
    check_now();
    step(0, 1, 0, 3'b001, 32'h33, 32'h0);
    expect_v(0, 32'h0, "lh33_rd"); expect_v(1, 32'h1, "lh33_mis");
    check_now();
    step(0, 0, 0, 3'b001, 32'h33, 32'h0);
    expect_v(3, 32'h21, "faddr_keep"); expect_v(1, 32'h0, "idle_mis");
    check_now();

    step(0, 0, 1, 3'b010, 32'h100, 32'h1);
    step(0, 1, 0, 3'b010, 32'h0, 32'h0);
    expect_v(0, 32'h1, "wrap_lw0"); expect_v(4, 32'd4, "wrap_cnt");
    check_now();

    step(1, 0, 1, 3'b010, 32'h4, 32'h2);
    step(0, 1, 0, 3'b010, 32'h4, 32'h0);
    expect_v(0, 32'h0, "rst_drop"); expect_v(2, 32'h0, "rst_sticky");
    expect_v(3, 32'h0, "rst_faddr"); expect_v(4, 32'h0, "rst_cnt");
    check_now();
    step(0, 1, 0, 3'b010, 32'h0, 32'h0); expect_v(0, 32'h0, "rst_clear_mem"); check_now();

    step(0, 0, 1, 3'b010, 32'h8, 32'h9);
    step(0, 1, 1, 3'b010, 32'h8, 32'h5);
    expect_v(0, 32'h9, "rdw_old"); expect_v(1, 32'h0, "rdw_mis");
    check_now();
    step(0, 1, 0, 3'b010, 32'h8, 32'h0);
    expect_v(0, 32'h5, "rdw_new"); expect_v(4, 32'd2, "rdw_cnt");
    check_now();
    exp_cnt = 2;

    while (exp_cnt < 16'hFFFE) begin
      step(0, 0, 1, 3'b010, 32'hC, 32'h0);
      exp_cnt++;
    end
    step(0, 0, 0, 3'b010, 32'hC, 32'h0); expect_v(4, 32'hFFFE, "cnt_fffe"); check_now();
    step(0, 0, 1, 3'b010, 32'hC, 32'h0);
    step(0, 0, 0, 3'b010, 32'hC, 32'h0); expect_v(4, 32'hFFFF, "cnt_ffff"); check_now();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3'b010, 32'hC, 32'h0);
    step(0, 0, 0, 3'b010, 32'hC, 32'h0); expect_v(4, 32'hFFFF, "cnt_sat"); check_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
